// File: rtl/logic_op_core.sv
// Two-stage valid/ready bitwise-logic datapath (AND/OR/XOR/NOT A) with full backpressure
// and a wrapping count of output handshakes.
module logic_op_core #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_logic_sel,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DW-1:0]    i_opa,
  input  logic [DW-1:0]    i_opb,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DW-1:0]    o_result,
  output logic [1:0]       o_op,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_beat_cnt,
  output logic             o_busy
);

  logic          s1_valid;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;
  logic [1:0]    s1_sel;
  logic          s2_valid;
  logic [DW-1:0] res_d;
  logic          s2_adv;
  logic          s1_adv;
  logic          accept;
  logic          out_hs;

  // o_ready depends combinationally on i_ready so a full pipe can still stream.
  assign s2_adv  = !s2_valid || i_ready;
  assign s1_adv  = s1_valid && s2_adv;
  assign o_ready = !s1_valid || s2_adv;
  assign accept  = i_valid && o_ready;
  assign out_hs  = s2_valid && i_ready;

  always_comb begin
    res_d = '0;
    case (s1_sel)
      2'b00:   res_d = s1_a & s1_b;
      2'b01:   res_d = s1_a | s1_b;
      2'b10:   res_d = s1_a ^ s1_b;
      default: res_d = ~s1_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= 2'b00;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= i_opa;
        s1_b     <= i_opb;
        s1_sel   <= i_logic_sel;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      o_result <= '0;
      o_op     <= 2'b00;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        o_result <= res_d;
        o_op     <= s1_sel;
      end else if (out_hs) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Clear wins over a coincident handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_beat_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_beat_cnt <= '0;
    end else if (out_hs) begin
      o_beat_cnt <= o_beat_cnt + CNT_W'(1);
    end
  end

  assign o_valid = s2_valid;
  assign o_busy  = s1_valid || s2_valid;

endmodule
